// File: rtl/axis_frame_limit.sv
// AXI4-Stream frame length policer: truncates oversize frames, bad-marks runts.
// Define AXIS_FRAME_LIMIT_STATS_EN to add saturating good/bad frame counters.
module axis_frame_limit #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int MAX_LEN    = 1518,
    parameter int MIN_LEN    = 1,
    parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  status_truncated,
    output logic                  status_runt,
    output logic [LEN_WIDTH-1:0]  status_frame_len
`ifdef AXIS_FRAME_LIMIT_STATS_EN
    ,
    output logic [31:0]           stat_good_frames,
    output logic [31:0]           stat_bad_frames
`endif
);

    typedef enum logic {
        ST_PASS,
        ST_DISCARD
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [LEN_WIDTH-1:0] r_beatCnt;
    logic [LEN_WIDTH-1:0] w_beatNum;
    logic                 w_outFree;
    logic                 w_load;
    logic                 w_truncate;
    logic                 w_runt;
    logic                 w_bad;
    logic                 w_frameEnd;

    assign w_outFree  = !m_axis_tvalid || m_axis_tready;
    assign w_beatNum  = r_beatCnt + LEN_WIDTH'(1);
    assign w_bad      = w_truncate || w_runt;
    assign w_frameEnd = w_load && (s_axis_tlast || w_truncate);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_PASS;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Truncation is only checked on non-last beats, so it wins over the runt check.
    always_comb begin
        w_nextState   = r_state;
        s_axis_tready = w_outFree;
        w_load        = 1'b0;
        w_truncate    = 1'b0;
        w_runt        = 1'b0;
        case (r_state)
            ST_PASS: begin
                if (s_axis_tvalid && w_outFree) begin
                    w_load = 1'b1;
                    if (s_axis_tlast) begin
                        w_runt = (int'(w_beatNum) < MIN_LEN);
                    end else if (w_beatNum == LEN_WIDTH'(MAX_LEN)) begin
                        w_truncate  = 1'b1;
                        w_nextState = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_nextState = ST_PASS;
                end
            end
            default: w_nextState = ST_PASS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beatCnt <= '0;
        end else if (w_load) begin
            r_beatCnt <= w_frameEnd ? '0 : w_beatNum;
        end
    end

    // Output register keeps draining even while the remainder of a frame is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (w_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= s_axis_tlast || w_truncate;
            m_axis_tuser  <= s_axis_tuser | USER_WIDTH'(w_bad);
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_truncated <= 1'b0;
            status_runt      <= 1'b0;
            status_frame_len <= '0;
        end else begin
            status_truncated <= w_truncate;
            status_runt      <= w_runt;
            if (w_frameEnd) begin
                status_frame_len <= w_beatNum;
            end
        end
    end

`ifdef AXIS_FRAME_LIMIT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_good_frames <= '0;
            stat_bad_frames  <= '0;
        end else begin
            if (w_frameEnd && !w_bad && (stat_good_frames != 32'hFFFF_FFFF)) begin
                stat_good_frames <= stat_good_frames + 32'd1;
            end
            if (w_bad && (stat_bad_frames != 32'hFFFF_FFFF)) begin
                stat_bad_frames <= stat_bad_frames + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_limit.sv
// Self-checking bench for axis_frame_limit (MAX_LEN=4, MIN_LEN=2) against a frame-level model.
// Honours AXIS_FRAME_LIMIT_STATS_EN when defined.
module tb_axis_frame_limit;

    localparam int MAX_LEN = 4;
    localparam int MIN_LEN = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [0:0]    s_axis_tuser = '0;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [0:0]    m_axis_tuser;
    logic          status_truncated;
    logic          status_runt;
    logic [LW-1:0] status_frame_len;
`ifdef AXIS_FRAME_LIMIT_STATS_EN
    logic [31:0]   stat_good_frames;
    logic [31:0]   stat_bad_frames;
`endif

    axis_frame_limit #(
        .DATA_WIDTH(8),
        .USER_WIDTH(1),
        .MAX_LEN   (MAX_LEN),
        .MIN_LEN   (MIN_LEN)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .status_truncated(status_truncated),
        .status_runt     (status_runt),
        .status_frame_len(status_frame_len)
`ifdef AXIS_FRAME_LIMIT_STATS_EN
        ,
        .stat_good_frames(stat_good_frames),
        .stat_bad_frames (stat_bad_frames)
`endif
    );

    always #5 clk = ~clk;

    // kind: 0 plain beat, 1 final beat of a truncated frame, 2 final beat of a runt frame
    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         kind;
        int         len;
    } beat_t;

    beat_t      expQ[$];
    logic [7:0] outLog[$];
    int         nChecks = 0;
    int         nFails = 0;
    int         expLen = 0;
    int         expGood = 0;
    int         expBad = 0;
    int         truncSeen = 0;
    int         runtSeen = 0;
    bit         randReady = 1'b0;
    bit         randGaps = 1'b0;
    bit         prevValid = 1'b0;
    bit         prevReady = 1'b0;
    logic [7:0] prevData = '0;
    logic       prevLast = 1'b0;
    logic       prevUser = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic sendBeat(input logic [7:0] d, input logic l, input logic u);
        int  waitCnt;
        bit  acc;
        waitCnt       = 0;
        acc           = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        do begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            waitCnt++;
        end while (!acc && waitCnt < 200);
        if (!acc) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL input_handshake: got no s_axis_tready in %0d cycles, required acceptance", waitCnt);
        end
        s_axis_tvalid = 1'b0;
        if (randGaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Builds a frame, records what must come out of the policer, then sends nSend of its beats.
    task automatic applyStimulus(input int len, input logic [7:0] base, input logic [7:0] step,
                                 input bit randData, input int nSend);
        logic [7:0] d[16];
        logic       u[16];
        int         emitN;
        bit         bad;
        beat_t      e;
        for (int i = 0; i < len; i++) begin
            d[i] = randData ? 8'($urandom) : 8'(base + 8'(i) * step);
            u[i] = (randData && i != len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        emitN = (len > MAX_LEN) ? MAX_LEN : len;
        bad   = (len > MAX_LEN) || (len < MIN_LEN);
        for (int i = 0; i < emitN; i++) begin
            e.data = d[i];
            e.last = (i == emitN - 1);
            e.user = u[i] | (e.last && bad);
            e.kind = !e.last ? 0 : (len > MAX_LEN) ? 1 : (len < MIN_LEN) ? 2 : 0;
            e.len  = emitN;
            expQ.push_back(e);
        end
        for (int i = 0; i < nSend; i++) begin
            sendBeat(d[i], (i == len - 1), u[i]);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (expQ.size() != 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain: got %0d beats still pending, required 0", expQ.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkLog(input string name, input logic [7:0] req[], input int reqN);
        checkOutput({name, "_count"}, 32'(outLog.size()), 32'(reqN));
        for (int i = 0; i < reqN && i < outLog.size(); i++) begin
            checkOutput({name, "_data"}, 32'(outLog[i]), 32'(req[i]));
        end
    endtask

    task automatic clearLogs();
        outLog.delete();
        truncSeen = 0;
        runtSeen  = 0;
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Cycle-by-cycle comparison against the expected beat queue
    initial begin
        beat_t e;
        bit    newBeat;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevValid = 1'b0;
                prevReady = 1'b0;
                continue;
            end
            if (prevValid && !prevReady) begin
                checkOutput("stall_valid", 32'(m_axis_tvalid), 32'd1);
                checkOutput("stall_data", 32'(m_axis_tdata), 32'(prevData));
                checkOutput("stall_last", 32'(m_axis_tlast), 32'(prevLast));
                checkOutput("stall_user", 32'(m_axis_tuser), 32'(prevUser));
            end
            if (status_truncated) truncSeen++;
            if (status_runt) runtSeen++;
            newBeat = m_axis_tvalid && !(prevValid && !prevReady);
            if (newBeat && expQ.size() != 0) begin
                e = expQ[0];
                checkOutput("trunc_pulse", 32'(status_truncated), 32'(e.kind == 1));
                checkOutput("runt_pulse", 32'(status_runt), 32'(e.kind == 2));
                if (e.last) begin
                    expLen = e.len;
                    if (e.kind == 0) expGood++;
                    else expBad++;
                end
            end else if (!newBeat) begin
                checkOutput("trunc_idle", 32'(status_truncated), 32'd0);
                checkOutput("runt_idle", 32'(status_runt), 32'd0);
            end
            checkOutput("frame_len", 32'(status_frame_len), 32'(expLen));
`ifdef AXIS_FRAME_LIMIT_STATS_EN
            checkOutput("stat_good", stat_good_frames, 32'(expGood));
            checkOutput("stat_bad", stat_bad_frames, 32'(expBad));
`endif
            if (m_axis_tvalid && expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_beat: got data %0h, required no beat", m_axis_tdata);
            end else if (m_axis_tvalid && m_axis_tready) begin
                e = expQ.pop_front();
                checkOutput("out_data", 32'(m_axis_tdata), 32'(e.data));
                checkOutput("out_last", 32'(m_axis_tlast), 32'(e.last));
                checkOutput("out_user", 32'(m_axis_tuser), 32'(e.user));
                outLog.push_back(m_axis_tdata);
            end
            prevValid = m_axis_tvalid;
            prevReady = m_axis_tready;
            prevData  = m_axis_tdata;
            prevLast  = m_axis_tlast;
            prevUser  = m_axis_tuser;
        end
    end

    initial begin
        logic [7:0] lit[];
        #3;
        checkOutput("rst_valid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst_data", 32'(m_axis_tdata), 32'd0);
        checkOutput("rst_last", 32'(m_axis_tlast), 32'd0);
        checkOutput("rst_user", 32'(m_axis_tuser), 32'd0);
        checkOutput("rst_trunc", 32'(status_truncated), 32'd0);
        checkOutput("rst_runt", 32'(status_runt), 32'd0);
        checkOutput("rst_len", 32'(status_frame_len), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] frame of 3 beats");
        clearLogs();
        applyStimulus(3, 8'h11, 8'h11, 1'b0, 3);
        waitDrain();
        lit = '{8'h11, 8'h22, 8'h33};
        checkLog("t1", lit, 3);
        checkOutput("t1_len", 32'(status_frame_len), 32'd3);
        checkOutput("t1_trunc_count", 32'(truncSeen), 32'd0);
        checkOutput("t1_runt_count", 32'(runtSeen), 32'd0);

        $display("[TB] oversize frame then 2-beat frame");
        clearLogs();
        applyStimulus(6, 8'hA0, 8'h01, 1'b0, 6);
        applyStimulus(2, 8'hB0, 8'h01, 1'b0, 2);
        waitDrain();
        lit = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1};
        checkLog("t2", lit, 6);
        checkOutput("t2_trunc_count", 32'(truncSeen), 32'd1);
        checkOutput("t2_len", 32'(status_frame_len), 32'd2);

        $display("[TB] frame of exactly MAX_LEN beats");
        clearLogs();
        applyStimulus(4, 8'hC0, 8'h01, 1'b0, 4);
        waitDrain();
        lit = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        checkLog("t3", lit, 4);
        checkOutput("t3_len", 32'(status_frame_len), 32'd4);
        checkOutput("t3_trunc_count", 32'(truncSeen), 32'd0);

        $display("[TB] runt frame");
        clearLogs();
        applyStimulus(1, 8'h5A, 8'h00, 1'b0, 1);
        waitDrain();
        lit = '{8'h5A};
        checkLog("t4", lit, 1);
        checkOutput("t4_runt_count", 32'(runtSeen), 32'd1);
        checkOutput("t4_len", 32'(status_frame_len), 32'd1);

        $display("[TB] random frames with output backpressure");
        randReady = 1'b1;
        randGaps  = 1'b1;
        for (int f = 0; f < 200; f++) begin
            int len;
            len = $urandom_range(1, 8);
            applyStimulus(len, 8'h00, 8'h00, 1'b1, len);
        end
        waitDrain();
        randReady = 1'b0;
        randGaps  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset in the middle of a frame");
        applyStimulus(6, 8'hD0, 8'h01, 1'b0, 2);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("mid_rst_data", 32'(m_axis_tdata), 32'd0);
        checkOutput("mid_rst_len", 32'(status_frame_len), 32'd0);
        expQ.delete();
        expLen  = 0;
        expGood = 0;
        expBad  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clearLogs();
        applyStimulus(3, 8'hE0, 8'h01, 1'b0, 3);
        waitDrain();
        lit = '{8'hE0, 8'hE1, 8'hE2};
        checkLog("t6", lit, 3);
        checkOutput("t6_len", 32'(status_frame_len), 32'd3);
`ifdef AXIS_FRAME_LIMIT_STATS_EN
        checkOutput("t6_good", stat_good_frames, 32'd1);
        checkOutput("t6_bad", stat_bad_frames, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
